// File: rtl/led_breather.sv
// led_breather: ramps an LED up and down through a PWM duty cycle so that an
// on/off request produces a smooth "breathing" LED instead of hard switching.
// Optional square-law brightness mapping is enabled with the macro
// LED_BREATHER_GAMMA_EN; without it the duty level equals the linear level.
module led_breather #(
    parameter int PWM_BITS    = 8,
    parameter int STEP_CYCLES = 4096
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_led,
    output logic                o_pwm,
    output logic [PWM_BITS-1:0] o_level,
    output logic                o_busy
);

    localparam int TMR_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PWM_BITS-1:0] LVL_FULL_C = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] LVL_ZERO_C = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] LVL_ONE_C  = {{(PWM_BITS-1){1'b0}}, 1'b1};
    localparam logic [TMR_W-1:0]    TMR_LAST_C = TMR_W'(STEP_CYCLES - 1);
    localparam logic [TMR_W-1:0]    TMR_ONE_C  = {{(TMR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RISE = 2'd1,
        ST_ON   = 2'd2,
        ST_FALL = 2'd3
    } state_t;

    state_t              state_r;
    logic                req_r;
    logic                busy_r;
    logic                pwm_r;
    logic [PWM_BITS-1:0] level_r;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [TMR_W-1:0]    timer_r;
    logic                step_s;
    logic [PWM_BITS-1:0] duty_s;

    assign step_s = (timer_r == TMR_LAST_C);

`ifdef LED_BREATHER_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_sq_s;

    // Square-law mapping: keep the upper half of level*level as the duty.
    always_comb begin
        level_sq_s = {{PWM_BITS{1'b0}}, level_r} * {{PWM_BITS{1'b0}}, level_r};
        duty_s     = level_sq_s[2*PWM_BITS-1:PWM_BITS];
    end
`else
    // Linear mapping: duty follows the brightness level directly.
    always_comb begin
        duty_s = level_r;
    end
`endif

    // Capture the request once; all state decisions use this registered copy.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            req_r <= 1'b0;
        end else begin
            req_r <= i_led;
        end
    end

    // Free-running PWM counter plus registered compare against the duty level.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pwm_cnt_r <= LVL_ZERO_C;
            pwm_r     <= 1'b0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + LVL_ONE_C;
            pwm_r     <= (pwm_cnt_r < duty_s);
        end
    end

    // Free-running step timer; the last count is the brightness step strobe.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            timer_r <= {TMR_W{1'b0}};
        end else if (step_s) begin
            timer_r <= {TMR_W{1'b0}};
        end else begin
            timer_r <= timer_r + TMR_ONE_C;
        end
    end

    // Ramp FSM: a direction change always wins over a coincident step, and
    // the level saturates at both ends (an end already reached settles at once).
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r <= ST_OFF;
            level_r <= LVL_ZERO_C;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_OFF: begin
                    level_r <= LVL_ZERO_C;
                    if (req_r) begin
                        state_r <= ST_RISE;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_RISE: begin
                    if (!req_r) begin
                        state_r <= ST_FALL;
                        busy_r  <= 1'b1;
                    end else if (level_r == LVL_FULL_C) begin
                        state_r <= ST_ON;
                        busy_r  <= 1'b0;
                    end else if (step_s) begin
                        level_r <= level_r + LVL_ONE_C;
                        if ((level_r + LVL_ONE_C) == LVL_FULL_C) begin
                            state_r <= ST_ON;
                            busy_r  <= 1'b0;
                        end else begin
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        busy_r  <= 1'b1;
                    end
                end
                ST_ON: begin
                    level_r <= LVL_FULL_C;
                    if (!req_r) begin
                        state_r <= ST_FALL;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_FALL: begin
                    if (req_r) begin
                        state_r <= ST_RISE;
                        busy_r  <= 1'b1;
                    end else if (level_r == LVL_ZERO_C) begin
                        state_r <= ST_OFF;
                        busy_r  <= 1'b0;
                    end else if (step_s) begin
                        level_r <= level_r - LVL_ONE_C;
                        if ((level_r - LVL_ONE_C) == LVL_ZERO_C) begin
                            state_r <= ST_OFF;
                            busy_r  <= 1'b0;
                        end else begin
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_OFF;
                    level_r <= LVL_ZERO_C;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_pwm   = pwm_r;
    assign o_level = level_r;
    assign o_busy  = busy_r;

endmodule

// File: tb/tb_led_breather.sv
// tb_led_breather: randomized and directed stimulus for led_breather checked
// every cycle against a direction/target reference model of the ramp.
module tb_led_breather;

    localparam int PB    = 4;
    localparam int STEP  = 2;
    localparam int FULL  = (1 << PB) - 1;

    logic          clk;
    logic          i_reset;
    logic          i_led;
    logic          o_pwm;
    logic [PB-1:0] o_level;
    logic          o_busy;

    int n_checks;
    int n_errors;

    // Reference model state
    int c_m;       // cycles since reset release
    int level_m;
    int busy_m;
    int pwm_m;
    int dir_m;     // 1 = heading to full scale, 0 = heading to zero
    int req_m;

    led_breather #(.PWM_BITS(PB), .STEP_CYCLES(STEP)) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_led   (i_led),
        .o_pwm   (o_pwm),
        .o_level (o_level),
        .o_busy  (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int duty_of(input int lvl);
`ifdef LED_BREATHER_GAMMA_EN
        return (lvl * lvl) >> PB;
`else
        return lvl;
`endif
    endfunction

    task automatic model_reset();
        c_m = 0; level_m = 0; busy_m = 0; pwm_m = 0; dir_m = 0; req_m = 0;
    endtask

    // One clock edge of the reference model; led is the input sampled at it.
    task automatic model_edge(input int led);
        int target;
        pwm_m  = ((c_m % (1 << PB)) < duty_of(level_m)) ? 1 : 0;
        target = dir_m ? FULL : 0;
        if (req_m != dir_m) begin
            dir_m  = req_m;
            busy_m = 1;
        end else if (level_m == target) begin
            busy_m = 0;
        end else begin
            if ((c_m % STEP) == STEP - 1)
                level_m = level_m + (dir_m ? 1 : -1);
            busy_m = (level_m != target) ? 1 : 0;
        end
        req_m = led;
        c_m++;
    endtask

    // Starts and ends at a negedge; drives i_led, clocks, checks all outputs.
    task automatic tick(input logic led);
        i_led = led;
        @(posedge clk);
        model_edge(int'(led));
        #1;
        check_val("level", int'(o_level), level_m);
        check_val("busy", int'(o_busy), busy_m);
        check_val("pwm", int'(o_pwm), pwm_m);
        @(negedge clk);
    endtask

    task automatic count_window(input logic led, input string tag, input int exp);
        int highs;
        highs = 0;
        for (int k = 0; k < (1 << PB); k++) begin
            tick(led);
            highs += int'(o_pwm);
        end
        check_val(tag, highs, exp);
    endtask

    initial begin
        int hold;
        int lvl_v;
        logic led_v;
        n_checks = 0;
        n_errors = 0;
        i_led    = 1'b0;
        i_reset  = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_level", int'(o_level), 0);
        check_val("rst_busy", int'(o_busy), 0);
        check_val("rst_pwm", int'(o_pwm), 0);
        @(negedge clk);
        i_reset = 1'b0;
        model_reset();

        // Idle OFF, then full rise with busy latency of two edges
        repeat (5) tick(1'b0);
        tick(1'b1);
        check_val("busy_lat1", int'(o_busy), 0);
        tick(1'b1);
        check_val("busy_lat2", int'(o_busy), 1);
        hold = 0;
        while (!(int'(o_level) == FULL && o_busy == 1'b0) && hold < 200) begin
            tick(1'b1);
            hold++;
        end
        check_val("reach_on", (hold < 200) ? 1 : 0, 1);
        count_window(1'b1, "duty_full", duty_of(FULL));

        // Fall to OFF, then duty at level 0
        hold = 0;
        while (!(int'(o_level) == 0 && o_busy == 1'b0) && hold < 200) begin
            tick(1'b0);
            hold++;
        end
        check_val("reach_off", (hold < 200) ? 1 : 0, 1);
        count_window(1'b0, "duty_zero", 0);

        // Reversal at level 7: falls back to 0 without wrapping
        hold = 0;
        while (int'(o_level) != 7 && hold < 100) begin
            tick(1'b1);
            hold++;
        end
        check_val("reach_7", int'(o_level), 7);
        for (int k = 0; k < 40; k++) tick(1'b0);
        check_val("rev_off_level", int'(o_level), 0);
        check_val("rev_off_busy", int'(o_busy), 0);

        // Asynchronous reset mid-ramp at level 7
        hold = 0;
        while (int'(o_level) != 7 && hold < 100) begin
            tick(1'b1);
            hold++;
        end
        check_val("reach_7b", int'(o_level), 7);
        #2;
        i_reset = 1'b1;
        #1;
        check_val("arst_level", int'(o_level), 0);
        check_val("arst_busy", int'(o_busy), 0);
        check_val("arst_pwm", int'(o_pwm), 0);
        @(posedge clk);
        @(negedge clk);
        i_reset = 1'b0;
        model_reset();
        for (int k = 0; k < 20; k++) tick(1'b0);
        check_val("post_rst_level", int'(o_level), 0);

        // Randomized request pattern with random hold lengths
        led_v = 1'b0;
        for (int k = 0; k < 300; k++) begin
            led_v = ~led_v;
            hold  = int'($urandom_range(1, 40));
            for (int j = 0; j < hold; j++) tick(led_v);
        end

        // Settle at ON for a final full-scale duty check
        for (int k = 0; k < 60; k++) tick(1'b1);
        lvl_v = int'(o_level);
        check_val("final_on_level", lvl_v, FULL);
        count_window(1'b1, "duty_full2", duty_of(FULL));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/led_breather.md
Name: led_breather

Overview:
- Downstream consumer of the counter-driven LED blink signal.
- Takes a 1-bit on/off request, e.g. a counter MSB, and drives the physical LED pin.
- Instead of hard switching, it ramps brightness up and down through a PWM duty cycle, giving a "breathing" LED.
- Sits between the blink/heartbeat generator and the top-level LED output pin.

Parameters:
- PWM_BITS, 8: width of PWM counter and brightness level; full scale is 2^PWM_BITS-1.
- STEP_CYCLES, 4096: clock cycles per one-LSB brightness change; legal range ≥1.

Ports:
- i_clk  input  1  system clock.
- i_reset  input  1  asynchronous, active-high reset.
- i_led  input  1  requested LED state (1 = on); same clock domain as i_clk.
- o_pwm  output  1  PWM drive to LED pin, registered.
- o_level  output  PWM_BITS  current brightness level.
- o_busy  output  1  high while ramping (RISE or FALL).

Behaviour:
- Interface: one clock, i_clk. Reset i_reset is asynchronous and active-high.
- Reset values: o_pwm=0, o_level=0, o_busy=0, state=OFF, PWM counter=0, step timer=0, request register=0. Reset asserted mid-ramp forces these values immediately; there is no completion of the ramp.
- Request path: i_led is registered once into req (1-cycle latency). State transitions use req.
- PWM counter: free-running, PWM_BITS wide, +1 every cycle, wraps from 2^PWM_BITS-1 to 0.
- Duty: o_pwm <= (pwm_cnt < duty_level), registered.
  - Level 0 gives constant 0.
  - Full scale gives high for 2^PWM_BITS-1 of every 2^PWM_BITS cycles (never constant 1).
- Step timer: free-running 0..STEP_CYCLES-1. step strobe = (timer == STEP_CYCLES-1). With STEP_CYCLES=1 the strobe is asserted every cycle.
- States:
  - OFF: level=0. req=1 -> RISE.
  - RISE: on strobe, level+1. If level reaches full scale -> ON. req=0 -> FALL with no level change that cycle.
  - ON: level=full scale. req=0 -> FALL.
  - FALL: on strobe, level-1. If level reaches 0 -> OFF. req=1 -> RISE with no level change that cycle.
- Simultaneous strobe and direction reversal: the reversal wins and the level holds for that cycle.
- Level saturates: it never wraps below 0 or above full scale.
- o_busy = (state==RISE || state==FALL), registered alongside state.
- o_level reflects the level register directly (no extra latency).
- Level changes may occur mid PWM period. Duty takes effect from the next compare cycle; glitch-free period alignment is not required.

Optional Feature:
- Macro: LED_BREATHER_GAMMA_EN.
- Defined: duty_level = (level*level) >> PWM_BITS, computed with a 2*PWM_BITS-wide product. This gives a perceptually linear square-law brightness. o_level still reports the linear level.
- Undefined: duty_level = level (linear); no multiplier is synthesized.

Test Plan:
- Reset mid-ramp: PWM_BITS=4, STEP_CYCLES=2, i_led=1, assert i_reset at level 7 -> o_level=0, o_pwm=0, o_busy=0 in the same cycle (async); after release, stays OFF while i_led=0.
- Full rise: PWM_BITS=4, STEP_CYCLES=2, i_led 0->1 -> o_busy rises 2 cycles after the edge; o_level increments every 2 cycles and reaches 15 after 15 strobes; o_busy falls in the cycle state enters ON.
- Duty accuracy: hold level 4 (PWM_BITS=4, gamma off) -> o_pwm high for exactly 4 of every 16 cycles. Level 0 -> 0 of 16. Level 15 -> 15 of 16.
- Reversal: rising at level 7, drop i_led -> state FALL, next strobe gives level 6, ramps to 0, then OFF with o_busy=0. No wrap to 15.
- Reversal coincident with strobe: i_led change lands on the strobe cycle -> level unchanged that cycle, direction flips, and the next strobe moves in the new direction.
- Gamma (LED_BREATHER_GAMMA_EN defined, PWM_BITS=4): level 8 -> o_pwm high 4 of 16 cycles, o_level=8. Level 15 -> 14 of 16.
